// File: rtl/csr_commit_buffer.sv
// Commit buffer for speculative CSR writes. Holds writes in ROB order and releases
// each one to the CSR file only when its instruction retires. A flush drops them all.
module csr_commit_buffer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CSR_WIDTH  = 64,
   parameter int unsigned CSR_ADDR_W = 12,
   parameter int unsigned ROB_ID_W   = 7,
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned PTR_W     = IDX_W + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  recoverFlag_i,
   input  logic                  exeValid_i,
   input  logic [ROB_ID_W-1:0]   exeRobId_i,
   input  logic                  csrWrEn_i,
   input  logic [CSR_ADDR_W-1:0] csrWrAddr_i,
   input  logic [CSR_WIDTH-1:0]  csrWrData_i,
   input  logic                  commitValid_i,
   input  logic [ROB_ID_W-1:0]   commitRobId_i,
   output logic                  csrCommitEn_o,
   output logic [CSR_ADDR_W-1:0] csrCommitAddr_o,
   output logic [CSR_WIDTH-1:0]  csrCommitData_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [IDX_W:0]        count_o,
   output logic                  overflowErr_o
);

   logic [ROB_ID_W-1:0]   rob_q  [DEPTH];
   logic [CSR_ADDR_W-1:0] addr_q [DEPTH];
   logic [CSR_WIDTH-1:0]  data_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [IDX_W-1:0] head_idx, tail_idx;

   logic full, empty;
   logic push_req, push, pop;

   logic                  commit_en_q;
   logic [CSR_ADDR_W-1:0] commit_addr_q;
   logic [CSR_WIDTH-1:0]  commit_data_q;
   logic                  overflow_q;

   assign head_idx = head_q[IDX_W-1:0];
   assign tail_idx = tail_q[IDX_W-1:0];

   // Status comes only from registered pointers, so no input reaches these outputs.
   always_comb begin
      full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
      empty = (head_q == tail_q);
   end

   always_comb begin
      push_req = exeValid_i & csrWrEn_i;
      push     = push_req & ~full & ~recoverFlag_i;
      pop      = commitValid_i & ~empty & (rob_q[head_idx] == commitRobId_i);
   end

   // The retiring instruction is older than any flush, so its pop survives recovery.
   always_comb begin
      head_d = head_q + PTR_W'(pop);
      tail_d = tail_q + PTR_W'(push);
      if (recoverFlag_i) begin
         tail_d = head_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            rob_q[i]  <= '0;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else if (push) begin
         rob_q[tail_idx]  <= exeRobId_i;
         addr_q[tail_idx] <= csrWrAddr_i;
         data_q[tail_idx] <= csrWrData_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         commit_en_q   <= 1'b0;
         commit_addr_q <= '0;
         commit_data_q <= '0;
      end else begin
         commit_en_q <= pop;
         if (pop) begin
            commit_addr_q <= addr_q[head_idx];
            commit_data_q <= data_q[head_idx];
         end
      end
   end

   // Sticky until reset: a dropped CSR write means issue failed to stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else if (push_req && full) begin
         overflow_q <= 1'b1;
      end
   end

   assign csrCommitEn_o   = commit_en_q;
   assign csrCommitAddr_o = commit_addr_q;
   assign csrCommitData_o = commit_data_q;
   assign full_o          = full;
   assign empty_o         = empty;
   assign count_o         = tail_q - head_q;
   assign overflowErr_o   = overflow_q;

endmodule

// File: tb/tb_csr_commit_buffer.sv
// Bench for csr_commit_buffer: a queue-based model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_csr_commit_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        recoverFlag_i = 1'b0;
   logic        exeValid_i = 1'b0;
   logic [6:0]  exeRobId_i = '0;
   logic        csrWrEn_i = 1'b0;
   logic [11:0] csrWrAddr_i = '0;
   logic [63:0] csrWrData_i = '0;
   logic        commitValid_i = 1'b0;
   logic [6:0]  commitRobId_i = '0;
   logic        csrCommitEn_o;
   logic [11:0] csrCommitAddr_o;
   logic [63:0] csrCommitData_o;
   logic        full_o, empty_o, overflowErr_o;
   logic [2:0]  count_o;

   int total = 0;
   int passed = 0;

   csr_commit_buffer #(
      .DEPTH(DEPTH), .CSR_WIDTH(64), .CSR_ADDR_W(12), .ROB_ID_W(7)
   ) dut (
      .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
      .exeValid_i(exeValid_i), .exeRobId_i(exeRobId_i), .csrWrEn_i(csrWrEn_i),
      .csrWrAddr_i(csrWrAddr_i), .csrWrData_i(csrWrData_i),
      .commitValid_i(commitValid_i), .commitRobId_i(commitRobId_i),
      .csrCommitEn_o(csrCommitEn_o), .csrCommitAddr_o(csrCommitAddr_o),
      .csrCommitData_o(csrCommitData_o), .full_o(full_o), .empty_o(empty_o),
      .count_o(count_o), .overflowErr_o(overflowErr_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      else passed++;
   endtask

   // Reference model: an ordered list of pending writes.
   typedef struct packed {
      logic [6:0]  rob;
      logic [11:0] addr;
      logic [63:0] data;
   } ent_t;

   ent_t        mq[$];
   logic        m_en = 1'b0;
   logic [11:0] m_addr = '0;
   logic [63:0] m_data = '0;
   logic        m_ovf = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_en   <= 1'b0;
         m_addr <= '0;
         m_data <= '0;
         m_ovf  <= 1'b0;
      end else begin
         automatic bit attempt  = exeValid_i && csrWrEn_i;
         automatic bit was_full = (mq.size() == DEPTH);
         automatic bit pop = commitValid_i && (mq.size() > 0) && (mq[0].rob == commitRobId_i);
         m_en <= pop;
         if (pop) begin
            m_addr <= mq[0].addr;
            m_data <= mq[0].data;
            void'(mq.pop_front());
         end
         if (attempt && was_full) m_ovf <= 1'b1;
         if (recoverFlag_i) mq.delete();
         else if (attempt && !was_full) mq.push_back('{exeRobId_i, csrWrAddr_i, csrWrData_i});
      end
   end

   always @(negedge clk) begin
      chk("m_en", {63'd0, csrCommitEn_o}, {63'd0, m_en});
      chk("m_addr", {52'd0, csrCommitAddr_o}, {52'd0, m_addr});
      chk("m_data", csrCommitData_o, m_data);
      chk("m_count", {61'd0, count_o}, 64'(mq.size()));
      chk("m_full", {63'd0, full_o}, {63'd0, (mq.size() == DEPTH)});
      chk("m_empty", {63'd0, empty_o}, {63'd0, (mq.size() == 0)});
      chk("m_ovf", {63'd0, overflowErr_o}, {63'd0, m_ovf});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exeValid_i    = 1'b0;
      csrWrEn_i     = 1'b0;
      commitValid_i = 1'b0;
      recoverFlag_i = 1'b0;
   endtask

   task automatic set_push(input logic [6:0] id, input logic [11:0] a, input logic [63:0] d);
      exeValid_i  = 1'b1;
      csrWrEn_i   = 1'b1;
      exeRobId_i  = id;
      csrWrAddr_i = a;
      csrWrData_i = d;
   endtask

   task automatic set_commit(input logic [6:0] id);
      commitValid_i = 1'b1;
      commitRobId_i = id;
   endtask

   initial begin
      reset = 1'b1;
      tick();
      tick();
      chk("rst_empty", {63'd0, empty_o}, 64'd1);
      chk("rst_count", {61'd0, count_o}, 64'd0);
      reset = 1'b0;
      tick();

      // Single write released on retire.
      set_push(7'd5, 12'h001, 64'hAA);
      tick();
      idle();
      set_commit(7'd5);
      tick();
      idle();
      chk("t1_en", {63'd0, csrCommitEn_o}, 64'd1);
      chk("t1_addr", {52'd0, csrCommitAddr_o}, 64'h001);
      chk("t1_data", csrCommitData_o, 64'hAA);
      chk("t1_empty", {63'd0, empty_o}, 64'd1);
      tick();
      chk("t1_pulse", {63'd0, csrCommitEn_o}, 64'd0);

      // Fill then overflow.
      for (int i = 1; i <= 4; i++) begin
         set_push(7'(i), 12'(i), 64'(i * 'h11));
         tick();
      end
      chk("t2_full", {63'd0, full_o}, 64'd1);
      chk("t2_count", {61'd0, count_o}, 64'd4);
      set_push(7'd5, 12'h005, 64'h55);
      tick();
      idle();
      chk("t2_ovf", {63'd0, overflowErr_o}, 64'd1);
      chk("t2_cnt4", {61'd0, count_o}, 64'd4);

      // Pop while full together with a push: freed slot is not reused.
      set_commit(7'd1);
      set_push(7'd6, 12'h006, 64'h66);
      tick();
      idle();
      chk("t3_en", {63'd0, csrCommitEn_o}, 64'd1);
      chk("t3_data", csrCommitData_o, 64'h11);
      chk("t3_count", {61'd0, count_o}, 64'd3);

      // Mismatched retire id.
      set_commit(7'd9);
      tick();
      idle();
      chk("t4_en", {63'd0, csrCommitEn_o}, 64'd0);
      chk("t4_count", {61'd0, count_o}, 64'd3);

      recoverFlag_i = 1'b1;
      tick();
      idle();
      chk("t5_flush", {61'd0, count_o}, 64'd0);
      chk("t5_ovf_sticky", {63'd0, overflowErr_o}, 64'd1);

      // Retire plus flush plus push in one cycle.
      for (int i = 3; i <= 5; i++) begin
         set_push(7'(i), 12'(12'h300 + i), 64'(64'hC00 + i));
         tick();
      end
      set_commit(7'd3);
      recoverFlag_i = 1'b1;
      set_push(7'd6, 12'h306, 64'hC06);
      tick();
      idle();
      chk("t6_en", {63'd0, csrCommitEn_o}, 64'd1);
      chk("t6_addr", {52'd0, csrCommitAddr_o}, 64'h303);
      chk("t6_count", {61'd0, count_o}, 64'd0);
      tick();
      chk("t6_pulse", {63'd0, csrCommitEn_o}, 64'd0);

      // Streaming push+pop across several pointer wraps.
      set_push(7'd10, 12'h10A, 64'hD0A);
      tick();
      for (int i = 0; i < 3 * DEPTH; i++) begin
         set_push(7'(11 + i), 12'(12'h10B + i), 64'(64'hD0B + i));
         set_commit(7'(10 + i));
         tick();
         chk("t7_count", {61'd0, count_o}, 64'd1);
         chk("t7_data", csrCommitData_o, 64'(64'hD0A + i));
      end
      idle();
      set_commit(7'd22);
      tick();
      idle();
      chk("t7_drain", {63'd0, empty_o}, 64'd1);
      chk("t7_last", {52'd0, csrCommitAddr_o}, 64'h116);

      // Reset with two entries held and a qualifying retire on the inputs.
      set_push(7'd20, 12'h020, 64'hE0);
      tick();
      set_push(7'd21, 12'h021, 64'hE1);
      tick();
      idle();
      chk("t8_count2", {61'd0, count_o}, 64'd2);
      set_commit(7'd20);
      #2;
      reset = 1'b1;
      #1;
      chk("t8_en", {63'd0, csrCommitEn_o}, 64'd0);
      chk("t8_count", {61'd0, count_o}, 64'd0);
      chk("t8_ovf", {63'd0, overflowErr_o}, 64'd0);
      chk("t8_addr", {52'd0, csrCommitAddr_o}, 64'h0);
      tick();
      reset = 1'b0;
      idle();
      tick();
      chk("t8_noemit", {63'd0, csrCommitEn_o}, 64'd0);
      chk("t8_empty", {63'd0, empty_o}, 64'd1);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
